bus_rr: RTL
===========

BUS_RR -- requirements
Module: bus_rr

Interface
REQ-001 SHALL have parameter NrHosts, default 2, number of host ports (1..8).
REQ-002 SHALL have parameter NrDevices, default 3, number of device ports (1..16).
REQ-003 SHALL have parameter DataWidth, default 32, data bus width.
REQ-004 SHALL have parameter AddressWidth, default 32, address bus width.
REQ-005 SHALL have parameter TimeoutCycles, default 16, response watchdog limit (used only when BUS_TIMEOUT_EN is defined).
REQ-006 SHALL have port clk_i, input, 1, the single clock.
REQ-007 SHALL have port rst_ni, input, 1, asynchronous active-low reset.
REQ-008 SHALL have per-host unpacked-array inputs host_req_i[1], host_addr_i[AW], host_we_i[1], host_be_i[DW/8], host_wdata_i[DW].
REQ-009 SHALL have per-host unpacked-array outputs host_gnt_o[1], host_rvalid_o[1], host_rdata_o[DW], host_err_o[1].
REQ-010 SHALL have per-device unpacked-array outputs device_req_o, device_addr_o, device_we_o, device_be_o, device_wdata_o.
REQ-011 SHALL have per-device unpacked-array inputs device_rvalid_i[1], device_rdata_i[DW], device_err_i[1].
REQ-012 SHALL have inputs cfg_device_addr_base[NrDevices][AW] and cfg_device_addr_mask[NrDevices][AW].

Function
REQ-013 Decode SHALL select the lowest-index device d with (addr & mask[d]) == base[d]; no match = decode error.
REQ-014 Arbitration SHALL be round-robin: search starts at priority pointer ptr, first requesting host wins.
REQ-015 host_gnt_o SHALL be combinational, asserted in the request cycle for the winner only, when grant is permitted.
REQ-016 Grant SHALL be permitted when state is IDLE, or in WAIT when the outstanding response completes in that same cycle (back-to-back).
REQ-017 On grant, ptr SHALL update to (winner+1) mod NrHosts at the next edge; ptr unchanged with no grant.
REQ-018 On grant to a mapped device, device_req_o[d] SHALL assert same cycle with winner's addr/we/be/wdata forwarded unmodified; all other device_req_o low.
REQ-019 FSM states SHALL be IDLE and WAIT; grant -> WAIT latching host index and device index (or decode-error flag); response with no new grant -> IDLE.
REQ-020 In WAIT, device_rvalid_i of the latched device SHALL drive host_rvalid_o, host_rdata_o, host_err_o of the latched host the same cycle; other hosts see rvalid=0.
REQ-021 Decode-error grant SHALL issue no device request; the next cycle host_rvalid_o=1, host_err_o=1, host_rdata_o=0.
REQ-022 Responses SHALL be generated for writes as well as reads (one rvalid per grant).
REQ-023 device_rvalid_i from a non-latched device, or in IDLE, SHALL be ignored.
REQ-024 Index widths SHALL be max(1,$clog2(N)).

Reset
REQ-025 Asynchronous reset SHALL force state=IDLE, ptr=0, latched indices=0, timeout counter=0.
REQ-026 During reset all host_gnt_o, host_rvalid_o, host_err_o, device_req_o SHALL be 0; rdata outputs 0.
REQ-027 Reset mid-transaction SHALL discard the outstanding response; a late device_rvalid_i after release SHALL be ignored.

Configuration
REQ-028 Macro BUS_TIMEOUT_EN defined: WAIT counter increments each cycle without response; at TimeoutCycles it SHALL return rvalid=1, err=1, rdata=0 to the latched host and go to IDLE.
REQ-029 BUS_TIMEOUT_EN undefined: no counter; WAIT persists until the device responds.

Structure
REQ-030 Shared package bus_pkg SHALL hold state enum (IDLE, WAIT), max host/device constants, and index-width helper.
REQ-031 One sub-module rr_arbiter (request vector, ptr in -> one-hot grant, winner index) SHALL be instantiated.

Verification
REQ-032 Hosts 0 and 1 request continuously to RAM (0x100004), 1-cycle responder -> grants alternate 0,1,0,1, one grant per cycle after first.
REQ-033 Host 1 reads 0x200000 (device 1 returns 0xDEADBEEF) -> host_rvalid_o[1]=1, rdata 0xDEADBEEF, host 0 rvalid=0.
REQ-034 Host 0 reads 0x500000 (unmapped) -> no device_req_o, next cycle rvalid=1, err=1, rdata=0.
REQ-035 BUS_TIMEOUT_EN, TimeoutCycles=4, device never responds -> err response exactly 4 cycles after grant, then new grant accepted.
REQ-036 rst_ni low while in WAIT, device rvalid one cycle after release -> no host_rvalid_o; ptr=0, host 0 wins next contention.

Source files
------------

// File: rtl/bus_pkg.sv
// bus_pkg: shared state type, size limits and index-width helper for bus_rr.
package bus_pkg;
    typedef enum logic {IDLE, WAIT} state_e;
    localparam int MaxHosts = 8;
    localparam int MaxDevices = 16;
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/bus_rr_if.sv
// bus_rr_if: host- and device-side signal bundle of the bus_rr interconnect.
interface bus_rr_if #(
    parameter int NrHosts = 2,
    parameter int NrDevices = 3,
    parameter int DataWidth = 32,
    parameter int AddressWidth = 32
);
    logic                    host_req_i           [NrHosts];
    logic [AddressWidth-1:0] host_addr_i          [NrHosts];
    logic                    host_we_i            [NrHosts];
    logic [DataWidth/8-1:0]  host_be_i            [NrHosts];
    logic [DataWidth-1:0]    host_wdata_i         [NrHosts];
    logic                    host_gnt_o           [NrHosts];
    logic                    host_rvalid_o        [NrHosts];
    logic [DataWidth-1:0]    host_rdata_o         [NrHosts];
    logic                    host_err_o           [NrHosts];
    logic                    device_req_o         [NrDevices];
    logic [AddressWidth-1:0] device_addr_o        [NrDevices];
    logic                    device_we_o          [NrDevices];
    logic [DataWidth/8-1:0]  device_be_o          [NrDevices];
    logic [DataWidth-1:0]    device_wdata_o       [NrDevices];
    logic                    device_rvalid_i      [NrDevices];
    logic [DataWidth-1:0]    device_rdata_i       [NrDevices];
    logic                    device_err_i         [NrDevices];
    logic [AddressWidth-1:0] cfg_device_addr_base [NrDevices];
    logic [AddressWidth-1:0] cfg_device_addr_mask [NrDevices];
    modport slave (
        input  host_req_i, host_addr_i, host_we_i, host_be_i, host_wdata_i,
        input  device_rvalid_i, device_rdata_i, device_err_i,
        input  cfg_device_addr_base, cfg_device_addr_mask,
        output host_gnt_o, host_rvalid_o, host_rdata_o, host_err_o,
        output device_req_o, device_addr_o, device_we_o, device_be_o, device_wdata_o
    );
    modport master (
        output host_req_i, host_addr_i, host_we_i, host_be_i, host_wdata_i,
        output device_rvalid_i, device_rdata_i, device_err_i,
        output cfg_device_addr_base, cfg_device_addr_mask,
        input  host_gnt_o, host_rvalid_o, host_rdata_o, host_err_o,
        input  device_req_o, device_addr_o, device_we_o, device_be_o, device_wdata_o
    );
endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter: picks the first requester at or after the priority pointer.
module rr_arbiter
    import bus_pkg::*;
#(
    parameter int N = 2,
    localparam int IW = idx_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          valid
);
    logic [IW-1:0] j;
    always_comb begin
        gnt = '0;
        idx = '0;
        valid = 1'b0;
        j = '0;
        for (int i = 0; i < N; i++) begin
            j = IW'((int'(ptr) + i) % N);
            if (!valid && req[j]) begin
                valid = 1'b1;
                gnt[j] = 1'b1;
                idx = j;
            end
        end
    end
endmodule

// File: rtl/bus_rr.sv
// bus_rr: round-robin multi-host to multi-device bus with address decode, one outstanding transfer.
// Define BUS_TIMEOUT_EN to add a response watchdog that errors out a silent device.
module bus_rr
    import bus_pkg::*;
#(
    parameter int NrHosts = 2,
    parameter int NrDevices = 3,
    parameter int DataWidth = 32,
    parameter int AddressWidth = 32,
    parameter int TimeoutCycles = 16
) (
    input logic     clk_i,
    input logic     rst_ni,
    bus_rr_if.slave bus
);
    localparam int HW = idx_w(NrHosts);
    localparam int DIW = idx_w(NrDevices);
    state_e               state;
    logic [HW-1:0]        ptr, host_q, win;
    logic [DIW-1:0]       dev_q, dev;
    logic                 dec_err_q, hit, any, grant, resp, dev_ok, to_hit, rsp_err;
    logic [DataWidth-1:0] rsp_data;
    logic [NrHosts-1:0]   req, gnt_vec;
    always_comb begin
        req = '0;
        for (int h = 0; h < NrHosts; h++) req[h] = bus.host_req_i[h];
    end
    rr_arbiter #(.N(NrHosts)) u_arb (.req, .ptr, .gnt(gnt_vec), .idx(win), .valid(any));
    // Scanning downwards leaves the lowest matching device selected.
    always_comb begin
        dev = '0;
        hit = 1'b0;
        for (int d = NrDevices - 1; d >= 0; d--)
            if ((bus.host_addr_i[win] & bus.cfg_device_addr_mask[d]) == bus.cfg_device_addr_base[d]) begin
                dev = DIW'(d);
                hit = 1'b1;
            end
    end
`ifdef BUS_TIMEOUT_EN
    localparam int CW = $clog2(TimeoutCycles + 1);
    logic [CW-1:0] cnt;
    assign to_hit = cnt == CW'(TimeoutCycles - 1);
    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) cnt <= '0;
        else cnt <= (state == WAIT && !resp) ? cnt + 1'b1 : '0;
`else
    assign to_hit = 1'b0;
`endif
    assign dev_ok = state == WAIT && !dec_err_q && bus.device_rvalid_i[dev_q];
    assign resp = state == WAIT && (dec_err_q || dev_ok || to_hit);
    assign grant = rst_ni && any && (state == IDLE || resp);
    assign rsp_err = dev_ok ? bus.device_err_i[dev_q] : 1'b1;
    assign rsp_data = dev_ok ? bus.device_rdata_i[dev_q] : '0;
    always_comb begin
        for (int h = 0; h < NrHosts; h++) begin
            bus.host_gnt_o[h] = grant && gnt_vec[h];
            bus.host_rvalid_o[h] = resp && host_q == HW'(h);
            bus.host_err_o[h] = resp && host_q == HW'(h) && rsp_err;
            bus.host_rdata_o[h] = (resp && host_q == HW'(h)) ? rsp_data : '0;
        end
        for (int d = 0; d < NrDevices; d++) begin
            bus.device_req_o[d] = grant && hit && dev == DIW'(d);
            bus.device_addr_o[d] = bus.host_addr_i[win];
            bus.device_we_o[d] = bus.host_we_i[win];
            bus.device_be_o[d] = bus.host_be_i[win];
            bus.device_wdata_o[d] = bus.host_wdata_i[win];
        end
    end
    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) begin
            state <= IDLE;
            ptr <= '0;
            host_q <= '0;
            dev_q <= '0;
            dec_err_q <= 1'b0;
        end else if (grant) begin
            state <= WAIT;
            ptr <= (win == HW'(NrHosts - 1)) ? '0 : win + 1'b1;
            host_q <= win;
            dev_q <= dev;
            dec_err_q <= !hit;
        end else if (resp) begin
            state <= IDLE;
        end
endmodule
